// File: rtl/toggle_counter.sv
// Modulo-MODULUS up/down counter built as a bank of T flip-flops (Q <= Q ^ T).
// Optional Gray-code output G is enabled by defining TOGGLE_CNT_GRAY_EN.
module toggle_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             TC
`ifdef TOGGLE_CNT_GRAY_EN
  ,
  output logic [WIDTH-1:0] G
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qbar_q, qbar_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] t_s;
  logic [WIDTH-1:0] load_val_s;
  logic             wrap_s;

  // Clamp the load value into the count range.
  always_comb begin
    if (D > MAX_VAL) begin
      load_val_s = MAX_VAL;
    end else begin
      load_val_s = D;
    end
  end

  // Next count and wrap detection; out-of-range states fall back into range.
  always_comb begin
    next_s = q_q;
    wrap_s = 1'b0;
    if (Load) begin
      next_s = load_val_s;
    end else if (Enable) begin
      if (Up) begin
        if (q_q >= MAX_VAL) begin
          next_s = ZERO_VAL;
          wrap_s = (q_q == MAX_VAL);
        end else begin
          next_s = q_q + ONE_VAL;
        end
      end else begin
        if (q_q == ZERO_VAL) begin
          next_s = MAX_VAL;
          wrap_s = 1'b1;
        end else if (q_q > MAX_VAL) begin
          next_s = MAX_VAL;
        end else begin
          next_s = q_q - ONE_VAL;
        end
      end
    end else begin
      next_s = q_q;
    end
  end

  // Toggle vector form: only bits that differ from the next count flip.
  always_comb begin
    t_s    = q_q ^ next_s;
    q_d    = q_q ^ t_s;
    qbar_d = ~q_d;
    tc_d   = wrap_s;
  end

  // Count, complement and terminal-count registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q    <= ZERO_VAL;
      qbar_q <= {WIDTH{1'b1}};
      tc_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      qbar_q <= qbar_d;
      tc_q   <= tc_d;
    end
  end

  assign Q    = q_q;
  assign Qbar = qbar_q;
  assign TC   = tc_q;

`ifdef TOGGLE_CNT_GRAY_EN
  logic [WIDTH-1:0] g_q, g_d;

  // Gray code of the next count, registered alongside Q.
  always_comb begin
    g_d = q_d ^ {1'b0, q_d[WIDTH-1:1]};
  end

  // Gray register shares the counter's reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      g_q <= ZERO_VAL;
    end else begin
      g_q <= g_d;
    end
  end

  assign G = g_q;
`endif

endmodule

// File: tb/tb_toggle_counter.sv
// Self-checking bench for toggle_counter (WIDTH=4, MODULUS=10): directed cases
// followed by randomized stimulus against a modulo-arithmetic reference model.
module tb_toggle_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic             Clock;
  logic             Reset;
  logic             Enable;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic             TC;
`ifdef TOGGLE_CNT_GRAY_EN
  logic [WIDTH-1:0] G;
`endif

  int n_checks;
  int n_errors;
  int exp_q;
  int exp_tc;

  toggle_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (Enable),
    .Up     (Up),
    .Load   (Load),
    .D      (D),
    .Q      (Q),
    .Qbar   (Qbar),
    .TC     (TC)
`ifdef TOGGLE_CNT_GRAY_EN
    ,
    .G      (G)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: counting in the integers modulo MODULUS.
  task automatic model_step(input bit rst, input bit en, input bit up, input bit ld, input int d);
    if (rst) begin
      exp_q  = 0;
      exp_tc = 0;
    end else if (ld) begin
      exp_q  = (d < MODULUS) ? d : MODULUS - 1;
      exp_tc = 0;
    end else if (en) begin
      if (up) begin
        exp_tc = (exp_q == MODULUS - 1) ? 1 : 0;
        exp_q  = (exp_q + 1) % MODULUS;
      end else begin
        exp_tc = (exp_q == 0) ? 1 : 0;
        exp_q  = (exp_q + MODULUS - 1) % MODULUS;
      end
    end else begin
      exp_tc = 0;
    end
  endtask

  task automatic cycle(input string tag, input bit rst, input bit en, input bit up,
                       input bit ld, input int d);
    Reset  = rst;
    Enable = en;
    Up     = up;
    Load   = ld;
    D      = d[WIDTH-1:0];
    @(posedge Clock);
    model_step(rst, en, up, ld, d);
    #1;
    check_eq({tag, ".q"},    int'(Q),    exp_q);
    check_eq({tag, ".qbar"}, int'(Qbar), (~exp_q) & ((1 << WIDTH) - 1));
    check_eq({tag, ".tc"},   int'(TC),   exp_tc);
`ifdef TOGGLE_CNT_GRAY_EN
    check_eq({tag, ".g"},    int'(G),    exp_q ^ (exp_q >> 1));
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_q    = 0;
    exp_tc   = 0;
    Reset    = 1'b1;
    Enable   = 1'b0;
    Up       = 1'b1;
    Load     = 1'b0;
    D        = '0;

    // Reset dominates Load and Enable.
    for (int i = 0; i < 2; i++) cycle("reset", 1'b1, 1'b1, 1'b1, 1'b1, 7);
    check_eq("reset_q_const", int'(Q), 0);
    check_eq("reset_qbar_const", int'(Qbar), 15);

    // Up-count through the wrap.
    for (int i = 0; i < 12; i++) cycle("up", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    check_eq("up_final_const", int'(Q), 2);

    // Down-count wrap from 0.
    cycle("down_ld0", 1'b0, 1'b0, 1'b1, 1'b1, 0);
    cycle("down_wrap", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    check_eq("down_wrap_q_const", int'(Q), 9);
    check_eq("down_wrap_tc_const", int'(TC), 1);
    cycle("down_next", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    check_eq("down_next_tc_const", int'(TC), 0);

    // Clamped load, then wrap from the loaded terminal value.
    cycle("clamp", 1'b0, 1'b1, 1'b1, 1'b1, 13);
    check_eq("clamp_q_const", int'(Q), 9);
    check_eq("clamp_tc_const", int'(TC), 0);
    cycle("clamp_wrap", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    check_eq("clamp_wrap_tc_const", int'(TC), 1);

    // Hold, then reset overriding load.
    cycle("ld5", 1'b0, 1'b0, 1'b0, 1'b1, 5);
    for (int i = 0; i < 3; i++) cycle("hold", 1'b0, 1'b0, 1'b1, 1'b0, 3);
    check_eq("hold_qbar_const", int'(Qbar), 10);
    cycle("rst_ld", 1'b1, 1'b1, 1'b1, 1'b1, 8);

    // Direction changes every cycle.
    for (int i = 0; i < 8; i++) cycle("alt", 1'b0, 1'b1, i[0], 1'b0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            ($urandom_range(31) == 0),
            ($urandom_range(3) != 0),
            $urandom_range(1) == 1,
            ($urandom_range(7) == 0),
            $urandom_range(15));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
